mtimer_clint: RTL



---
 rtl/mtimer_clint.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mtimer_clint.sv
// ---------------------------------------------------------------------------
// mtimer_clint
//
// Machine-level core-local interruptor. Holds the 64-bit mtime counter, the
// 64-bit mtimecmp compare register and the msip software-interrupt bit behind
// a single-cycle memory-mapped slave port, and synchronizes the asynchronous
// external interrupt line. Produces the 32-bit interrupt vector with
// MSIP (bit 3), MTIP (bit 7) and MEIP (bit 11).
//
// Register map (word aligned, bus_addr[1:0] ignored):
//   0x0000          msip      bit 0 R/W, bits 31:1 read 0
//   0x4000 / 0x4004 mtimecmp  lo / hi, R/W
//   0xBFF8 / 0xBFFC mtime     lo / hi, R/W
//   anything else   reads 0, writes ignored, still acknowledged
//
// Parameters:
//   PRESCALE    core clock cycles per mtime increment (>= 1)
//
// Ports:
//   clk         core clock, the only clock
//   rst_n       synchronous active-low reset
//   bus_req     request valid, accepted every cycle it is high
//   bus_we      1 = write, 0 = read
//   bus_addr    byte address
//   bus_wdata   full-word write data
//   bus_ack     one-cycle pulse for the request of the previous edge
//   bus_rdata   read data while bus_ack is high, otherwise 0
//   ext_irq     asynchronous level-sensitive external interrupt
//   interrupts  interrupt vector to the core's interrupt controller
// ---------------------------------------------------------------------------
module mtimer_clint #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq,
  output logic [31:0] interrupts
);

  // Prescaler width; a one-bit counter is kept even when PRESCALE is 1.
  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRE_ONE = PW'(1);

  // Word addresses (bus_addr[15:2]).
  localparam logic [13:0] A_MSIP    = 14'h0000;
  localparam logic [13:0] A_CMP_LO  = 14'h1000;
  localparam logic [13:0] A_CMP_HI  = 14'h1001;
  localparam logic [13:0] A_TIME_LO = 14'h2FFE;
  localparam logic [13:0] A_TIME_HI = 14'h2FFF;

  // Architectural state
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic [PW-1:0] r_pre;
  logic          r_msip;
  logic          r_mtip;
  logic          r_ext_s1;
  logic          r_ext_s2;
  logic          r_ack;
  logic [31:0]   r_rdata;

  // Decode
  logic [13:0]   w_word;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_msip;
  logic          w_wr_cmp_lo;
  logic          w_wr_cmp_hi;
  logic          w_wr_time_lo;
  logic          w_wr_time_hi;
  logic          w_tick;
  logic [31:0]   w_rd_mux;
  logic          w_unused_addr;

  assign w_word        = bus_addr[15:2];
  assign w_unused_addr = ^bus_addr[1:0];

  assign w_wr          = bus_req &  bus_we;
  assign w_rd          = bus_req & ~bus_we;

  assign w_wr_msip     = w_wr && (w_word == A_MSIP);
  assign w_wr_cmp_lo   = w_wr && (w_word == A_CMP_LO);
  assign w_wr_cmp_hi   = w_wr && (w_word == A_CMP_HI);
  assign w_wr_time_lo  = w_wr && (w_word == A_TIME_LO);
  assign w_wr_time_hi  = w_wr && (w_word == A_TIME_HI);

  // Terminal count of the prescaler; always true when PRESCALE is 1.
  assign w_tick        = (r_pre == PRE_MAX);

  // Read mux sees the pre-edge register values, so a read returns the state
  // before any write or increment landing on the same edge.
  always_comb begin
    w_rd_mux = '0;
    case (w_word)
      A_MSIP:    w_rd_mux = {31'b0, r_msip};
      A_CMP_LO:  w_rd_mux = r_mtimecmp[31:0];
      A_CMP_HI:  w_rd_mux = r_mtimecmp[63:32];
      A_TIME_LO: w_rd_mux = r_mtime[31:0];
      A_TIME_HI: w_rd_mux = r_mtime[63:32];
      default:   w_rd_mux = '0;
    endcase
  end

  // mtime and prescaler. A bus write to either half wins over the increment
  // and restarts the prescale period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mtime <= '0;
      r_pre   <= '0;
    end else if (w_wr_time_lo) begin
      r_mtime[31:0] <= bus_wdata;
      r_pre         <= '0;
    end else if (w_wr_time_hi) begin
      r_mtime[63:32] <= bus_wdata;
      r_pre          <= '0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
      r_pre   <= '0;
    end else begin
      r_pre   <= r_pre + PRE_ONE;
    end
  end

  // mtimecmp, reset to all ones so no timer interrupt fires out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mtimecmp <= '1;
    end else if (w_wr_cmp_lo) begin
      r_mtimecmp[31:0] <= bus_wdata;
    end else if (w_wr_cmp_hi) begin
      r_mtimecmp[63:32] <= bus_wdata;
    end
  end

  // Software interrupt bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_msip <= 1'b0;
    end else if (w_wr_msip) begin
      r_msip <= bus_wdata[0];
    end
  end

  // Timer compare on current register values; one edge behind any change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  // Two-flop synchronizer for the asynchronous external interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
    end else begin
      r_ext_s1 <= ext_irq;
      r_ext_s2 <= r_ext_s1;
    end
  end

  // Bus response: one cycle after the request, zero data on writes and idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus_req;
      r_rdata <= w_rd ? w_rd_mux : 32'd0;
    end
  end

  assign bus_ack    = r_ack;
  assign bus_rdata  = r_rdata;
  assign interrupts = {20'b0, r_ext_s2, 3'b0, r_mtip, 3'b0, r_msip, 3'b0};

endmodule
